// File: rtl/arr_pkg.sv
// Shared definitions for the 2x2 array result collector.
// Holds the accumulator/output widths, the collector state encoding,
// the result-entry payload and the saturating narrowing helper.
// The collector selects saturation with the ARR_COLL_SAT_EN macro.
package arr_pkg;

    localparam int unsigned ACC_W = 24;
    localparam int unsigned OUT_W = 16;

    // Collector state enum, kept as plain constants for legacy tools
    typedef logic [1:0] coll_state_t;
    localparam coll_state_t ST_IDLE = 2'd0;
    localparam coll_state_t ST_WAIT = 2'd1;
    localparam coll_state_t ST_CAP1 = 2'd2;
    localparam coll_state_t ST_CAP2 = 2'd3;

    typedef struct packed {
        logic [OUT_W-1:0] val;
        logic             sat;
    } narrow_t;

    typedef struct packed {
        logic [OUT_W-1:0] c1;
        logic [OUT_W-1:0] c2;
        logic             sat;
    } res_entry_t;

    // Clamp a signed accumulator into the signed output range
    function automatic narrow_t sat_narrow(input logic [ACC_W-1:0] acc);
        narrow_t r;
        logic [ACC_W-OUT_W:0] hi;
        hi = acc[ACC_W-1:OUT_W-1];
        if ((&hi) || !(|hi)) begin
            r = '{val: acc[OUT_W-1:0], sat: 1'b0};
        end else if (acc[ACC_W-1]) begin
            r = '{val: {1'b1, {(OUT_W-1){1'b0}}}, sat: 1'b1};
        end else begin
            r = '{val: {1'b0, {(OUT_W-1){1'b1}}}, sat: 1'b1};
        end
        return r;
    endfunction

endpackage

// File: rtl/arr_res_fifo.sv
// Result FIFO with a registered head.
// Ports: clk, rst_n; push/wdata write side; pop/rdata/valid read side;
// cnt = occupancy. valid rises one cycle after a push into an empty FIFO.
module arr_res_fifo #(
    parameter int unsigned W     = 33,
    parameter int unsigned DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    push,
    input  logic [W-1:0]            wdata,
    input  logic                    pop,
    output logic [W-1:0]            rdata,
    output logic                    valid,
    output logic [$clog2(DEPTH):0]  cnt
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_next;
    logic [CNT_W-1:0] cnt_next;
    logic             do_push;
    logic             do_pop;

    // Pointer/count next values; pointers wrap naturally (DEPTH is 2^n)
    always_comb begin
        do_pop   = pop && valid;
        do_push  = push && ((cnt < CNT_W'(DEPTH)) || do_pop);
        rd_next  = rd_ptr + PTR_W'(do_pop);
        cnt_next = cnt + CNT_W'(do_push) - CNT_W'(do_pop);
    end

    // Storage, pointers and registered head; bypass when the new head is written now
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
            valid  <= 1'b0;
            rdata  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (do_push) mem[wr_ptr] <= wdata;
            wr_ptr <= wr_ptr + PTR_W'(do_push);
            rd_ptr <= rd_next;
            cnt    <= cnt_next;
            valid  <= (cnt_next != '0) && (cnt != '0);
            rdata  <= (do_push && (wr_ptr == rd_next)) ? wdata : mem[rd_next];
        end
    end

endmodule

// File: rtl/arr2x2_collector.sv
// Collects the skewed column accumulators of a 2x2 array pass, narrows
// them to 16 bits and queues the result pairs in a FIFO.
// Ports: clk, rst_n, hold, start/start_rdy, c1_in/c2_in (24b signed),
// res_valid/res_ready/res_c1/res_c2/sat_flag, busy, fifo_cnt.
// Define ARR_COLL_SAT_EN for saturating narrowing (default: truncation).
module arr2x2_collector
    import arr_pkg::*;
#(
    parameter int unsigned LAT   = 3,
    parameter int unsigned DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    hold,
    input  logic                    start,
    output logic                    start_rdy,
    input  logic [ACC_W-1:0]        c1_in,
    input  logic [ACC_W-1:0]        c2_in,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic [OUT_W-1:0]        res_c1,
    output logic [OUT_W-1:0]        res_c2,
    output logic                    sat_flag,
    output logic                    busy,
    output logic [$clog2(DEPTH):0]  fifo_cnt
);

    localparam int unsigned CNT_W  = $clog2(DEPTH) + 1;
    localparam int unsigned LCNT_W = $clog2(LAT + 1);

    coll_state_t       state;
    coll_state_t       state_next;
    logic [LCNT_W-1:0] lcnt;
    logic [LCNT_W-1:0] lcnt_next;
    narrow_t           c1_q;
    narrow_t           c1_q_next;
    narrow_t           c1_n;
    narrow_t           c2_n;
    res_entry_t        entry;
    res_entry_t        head;
    logic              push;
    logic              pop;
    logic [CNT_W-1:0]  cnt_next;

`ifdef ARR_COLL_SAT_EN
    assign c1_n = sat_narrow(c1_in);
    assign c2_n = sat_narrow(c2_in);
`else
    logic unused_hi;
    assign c1_n = '{val: c1_in[OUT_W-1:0], sat: 1'b0};
    assign c2_n = '{val: c2_in[OUT_W-1:0], sat: 1'b0};
    assign unused_hi = ^{c1_in[ACC_W-1:OUT_W], c2_in[ACC_W-1:OUT_W]};
`endif

    // Next-state logic; hold freezes the whole capture side
    always_comb begin
        state_next = state;
        lcnt_next  = lcnt;
        c1_q_next  = c1_q;
        push       = 1'b0;
        if (!hold) begin
            case (state)
                ST_IDLE: begin
                    if (start && start_rdy) begin
                        lcnt_next  = LCNT_W'(LAT - 1);
                        state_next = (LAT == 1) ? ST_CAP1 : ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    lcnt_next = lcnt - LCNT_W'(1);
                    if (lcnt <= LCNT_W'(1)) state_next = ST_CAP1;
                end
                ST_CAP1: begin
                    c1_q_next  = c1_n;
                    state_next = ST_CAP2;
                end
                ST_CAP2: begin
                    push       = 1'b1;
                    state_next = ST_IDLE;
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    assign entry    = '{c1: c1_q.val, c2: c2_n.val, sat: c1_q.sat | c2_n.sat};
    assign pop      = res_valid && res_ready;
    assign cnt_next = fifo_cnt + CNT_W'(push) - CNT_W'(pop);

    // State register plus registered handshake/status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            lcnt      <= '0;
            c1_q      <= '0;
            busy      <= 1'b0;
            start_rdy <= 1'b0;
        end else begin
            state     <= state_next;
            lcnt      <= lcnt_next;
            c1_q      <= c1_q_next;
            busy      <= (state_next != ST_IDLE);
            start_rdy <= (state_next == ST_IDLE) && (cnt_next < CNT_W'(DEPTH));
        end
    end

    arr_res_fifo #(
        .W     ($bits(res_entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .wdata (entry),
        .pop   (pop),
        .rdata (head),
        .valid (res_valid),
        .cnt   (fifo_cnt)
    );

    assign res_c1   = head.c1;
    assign res_c2   = head.c2;
    assign sat_flag = head.sat;

endmodule

// File: tb/tb_arr2x2_collector.sv
// Self-checking bench for arr2x2_collector (LAT=3, DEPTH=4).
// Expected values follow ARR_COLL_SAT_EN when it is defined.
module tb_arr2x2_collector;

`ifdef ARR_COLL_SAT_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif
    localparam logic [23:0] JUNK = 24'hA5A5A5;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        hold;
    logic        start;
    logic        start_rdy;
    logic [23:0] c1_in;
    logic [23:0] c2_in;
    logic        res_valid;
    logic        res_ready;
    logic [15:0] res_c1;
    logic [15:0] res_c2;
    logic        sat_flag;
    logic        busy;
    logic [2:0]  fifo_cnt;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [23:0] c1;
        logic [23:0] c2;
        int          hold_cyc;
        logic [15:0] e1;
        logic [15:0] e2;
        logic        es;
    } vec_t;

    vec_t        vecs [6];
    logic [23:0] oc1 [4];

    always #5 clk = ~clk;

    arr2x2_collector #(.LAT(3), .DEPTH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .hold      (hold),
        .start     (start),
        .start_rdy (start_rdy),
        .c1_in     (c1_in),
        .c2_in     (c2_in),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_c1    (res_c1),
        .res_c2    (res_c2),
        .sat_flag  (sat_flag),
        .busy      (busy),
        .fifo_cnt  (fifo_cnt)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
        end
    endtask

    task automatic wait_rdy;
        int n = 0;
        while (start_rdy !== 1'b1 && n < 20) begin
            tick;
            n++;
        end
        chk("start_rdy_wait", 32'(start_rdy), 32'd1);
    endtask

    // One pass: start at cycle 0, optional hold during WAIT, samples at 3+h / 4+h.
    // Returns at cycle 5+h.
    task automatic run_pass(input logic [23:0] a, input logic [23:0] b,
                            input int h, input bit pop_on_push);
        start = 1'b1;
        tick;
        start = 1'b0;
        if (h > 0) begin
            hold = 1'b1;
            repeat (h) tick;
            hold = 1'b0;
        end
        tick;
        tick;
        c1_in = a;
        tick;
        c1_in = JUNK;
        c2_in = b;
        if (pop_on_push) res_ready = 1'b1;
        tick;
        c2_in = JUNK;
        if (pop_on_push) res_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = '{24'h000100, 24'h0000FF, 0, 16'h0100, 16'h00FF, 1'b0};
        vecs[1] = '{24'h012345, 24'hFF0000, 0,
                    SAT_EN ? 16'h7FFF : 16'h2345, SAT_EN ? 16'h8000 : 16'h0000, SAT_EN};
        vecs[2] = '{24'hFFFF80, 24'h007FFF, 2, 16'hFF80, 16'h7FFF, 1'b0};
        vecs[3] = '{24'hFF8000, 24'h000000, 0, 16'h8000, 16'h0000, 1'b0};
        vecs[4] = '{24'h008000, 24'hFF7FFF, 0,
                    SAT_EN ? 16'h7FFF : 16'h8000, SAT_EN ? 16'h8000 : 16'h7FFF, SAT_EN};
        vecs[5] = '{24'h000000, 24'h800000, 1,
                    16'h0000, SAT_EN ? 16'h8000 : 16'h0000, SAT_EN};
        oc1[0] = 24'h000011;
        oc1[1] = 24'h000022;
        oc1[2] = 24'h000033;
        oc1[3] = 24'h000044;

        rst_n     = 1'b0;
        hold      = 1'b0;
        start     = 1'b0;
        res_ready = 1'b0;
        c1_in     = JUNK;
        c2_in     = JUNK;
        repeat (2) tick;

        // Reset values
        chk("rst_valid", 32'(res_valid), 32'd0);
        chk("rst_cnt", 32'(fifo_cnt), 32'd0);
        chk("rst_rdy", 32'(start_rdy), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_c1", 32'(res_c1), 32'd0);
        chk("rst_c2", 32'(res_c2), 32'd0);
        chk("rst_sat", 32'(sat_flag), 32'd0);
        rst_n = 1'b1;
        #1;
        chk("rdy_before_edge", 32'(start_rdy), 32'd0);
        tick;
        chk("rdy_after_release", 32'(start_rdy), 32'd1);

        // Table-driven single passes, consumer always ready
        res_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            wait_rdy;
            run_pass(vecs[i].c1, vecs[i].c2, vecs[i].hold_cyc, 1'b0);
            chk($sformatf("v%0d_valid_early", i), 32'(res_valid), 32'd0);
            chk($sformatf("v%0d_busy_idle", i), 32'(busy), 32'd0);
            tick;
            chk($sformatf("v%0d_valid", i), 32'(res_valid), 32'd1);
            chk($sformatf("v%0d_c1", i), 32'(res_c1), 32'(vecs[i].e1));
            chk($sformatf("v%0d_c2", i), 32'(res_c2), 32'(vecs[i].e2));
            chk($sformatf("v%0d_sat", i), 32'(sat_flag), 32'(vecs[i].es));
            chk($sformatf("v%0d_cnt", i), 32'(fifo_cnt), 32'd1);
            tick;
            chk($sformatf("v%0d_valid_popped", i), 32'(res_valid), 32'd0);
            chk($sformatf("v%0d_cnt_popped", i), 32'(fifo_cnt), 32'd0);
        end

        // Fill the FIFO with the consumer stalled, then check order
        res_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            wait_rdy;
            run_pass(oc1[k], oc1[k] + 24'h000100, 0, 1'b0);
        end
        chk("full_cnt", 32'(fifo_cnt), 32'd4);
        chk("full_rdy", 32'(start_rdy), 32'd0);
        start = 1'b1;
        tick;
        start = 1'b0;
        chk("full_start_ignored", 32'(busy), 32'd0);
        chk("full_head_valid", 32'(res_valid), 32'd1);
        chk("full_head_c1", 32'(res_c1), 32'h0011);
        chk("full_head_c2", 32'(res_c2), 32'h0111);
        res_ready = 1'b1;
        tick;
        res_ready = 1'b0;
        chk("pop1_cnt", 32'(fifo_cnt), 32'd3);
        chk("pop1_rdy", 32'(start_rdy), 32'd1);
        res_ready = 1'b1;
        for (int k = 1; k < 4; k++) begin
            chk($sformatf("order%0d_valid", k), 32'(res_valid), 32'd1);
            chk($sformatf("order%0d_c1", k), 32'(res_c1), 32'(oc1[k][15:0]));
            tick;
        end
        res_ready = 1'b0;
        chk("drain_valid", 32'(res_valid), 32'd0);
        chk("drain_cnt", 32'(fifo_cnt), 32'd0);

        // Push and pop on the same edge keep the count and order
        wait_rdy;
        run_pass(24'h000055, 24'h000066, 0, 1'b0);
        tick;
        chk("pp_first_c1", 32'(res_c1), 32'h0055);
        wait_rdy;
        run_pass(24'h000077, 24'h000088, 0, 1'b1);
        chk("pp_cnt", 32'(fifo_cnt), 32'd1);
        chk("pp_valid", 32'(res_valid), 32'd1);
        chk("pp_c1", 32'(res_c1), 32'h0077);
        chk("pp_c2", 32'(res_c2), 32'h0088);
        res_ready = 1'b1;
        tick;
        res_ready = 1'b0;
        chk("pp_drained", 32'(fifo_cnt), 32'd0);

        // start pulsed during CAP1 is ignored
        wait_rdy;
        start = 1'b1;
        tick;
        start = 1'b0;
        tick;
        tick;
        c1_in = 24'h000123;
        start = 1'b1;
        tick;
        start = 1'b0;
        c1_in = JUNK;
        c2_in = 24'h000456;
        tick;
        c2_in = JUNK;
        chk("cap1_start_busy", 32'(busy), 32'd0);
        repeat (8) tick;
        chk("cap1_start_cnt", 32'(fifo_cnt), 32'd1);
        chk("cap1_start_c1", 32'(res_c1), 32'h0123);
        chk("cap1_start_c2", 32'(res_c2), 32'h0456);
        res_ready = 1'b1;
        tick;
        res_ready = 1'b0;
        chk("cap1_start_drained", 32'(fifo_cnt), 32'd0);

        // Reset during CAP1 abandons the pass
        wait_rdy;
        start = 1'b1;
        tick;
        start = 1'b0;
        tick;
        tick;
        c1_in = 24'h000999;
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_rdy", 32'(start_rdy), 32'd0);
        chk("midrst_cnt", 32'(fifo_cnt), 32'd0);
        chk("midrst_valid", 32'(res_valid), 32'd0);
        tick;
        c1_in = JUNK;
        rst_n = 1'b1;
        tick;
        chk("midrst_rdy_after", 32'(start_rdy), 32'd1);
        repeat (5) tick;
        chk("midrst_no_push", 32'(fifo_cnt), 32'd0);
        chk("midrst_valid_after", 32'(res_valid), 32'd0);
        chk("midrst_busy_after", 32'(busy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/arr2x2_collector.md
ARR2X2_COLLECTOR -- requirements
Module: arr2x2_collector

Interface
REQ-001 Parameter LAT, default 3, SHALL set the non-hold cycles from accepted start to the c1_in sample point.
REQ-002 Parameter DEPTH, default 4, SHALL set the number of result FIFO entries; it is a power of two and at least 2.
REQ-003 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 hold  input  1  SHALL freeze the capture side, in step with the array hold.
REQ-006 start  input  1  SHALL request one 2x2 array pass.
REQ-007 start_rdy  output  1  SHALL indicate that a start will be accepted.
REQ-008 c1_in, c2_in  input  24 each  SHALL carry the signed column accumulators from the array.
REQ-009 res_valid  output  1  SHALL indicate that the FIFO head is valid.
REQ-010 res_ready  input  1  SHALL indicate that the consumer accepts the head.
REQ-011 res_c1, res_c2  output  16 each  SHALL carry the signed result pair at the FIFO head.
REQ-012 sat_flag  output  1  SHALL indicate that the head entry was saturated.
REQ-013 busy  output  1  SHALL be high while a pass is in flight.
REQ-014 fifo_cnt  output  $clog2(DEPTH)+1  SHALL report FIFO occupancy.

Function
REQ-015 Start SHALL be accepted only on a cycle with start && start_rdy && !hold.
REQ-016 start_rdy SHALL equal (state==IDLE) && (fifo_cnt<DEPTH), so at most one pass is in flight and a push never overflows.
REQ-017 FSM states SHALL be IDLE, WAIT, CAP1 and CAP2.
REQ-018 On accept, the FSM SHALL go IDLE->WAIT and load the counter with LAT-1.
REQ-019 WAIT SHALL decrement the counter and SHALL go to CAP1 at zero.
REQ-020 CAP1 SHALL register c1_in and go to CAP2.
REQ-021 CAP2 SHALL register c2_in, push {c1, c2, sat} and return to IDLE.
REQ-022 The c2 sample SHALL be taken one non-hold cycle after the c1 sample, matching the column skew.
REQ-023 With hold high, the FSM, counter and capture registers SHALL keep their values; the FIFO pop side is unaffected by hold.
REQ-024 res_valid SHALL rise the cycle after a push into an empty FIFO.
REQ-025 A pop SHALL occur on res_valid && res_ready.
REQ-026 A simultaneous push and pop SHALL leave fifo_cnt unchanged and preserve FIFO order.
REQ-027 FIFO pointers SHALL wrap modulo DEPTH.
REQ-028 start while busy SHALL be ignored; there is no queueing of starts.
REQ-029 Narrowing from 24 to 16 bits SHALL follow the Configuration section.

Reset
REQ-030 rst_n low SHALL immediately force state IDLE, counter 0, FIFO empty, res_valid=0, res_c1=res_c2=0, sat_flag=0, busy=0 and fifo_cnt=0.
REQ-031 While rst_n is low, start_rdy SHALL be 0; it SHALL rise on the first clock edge after reset is released.
REQ-032 Reset asserted mid-pass SHALL abandon the pass with no partial push.

Configuration
REQ-033 With ARR_COLL_SAT_EN defined, each value SHALL clamp to [-32768, 32767], and sat_flag SHALL be the OR of the per-column clamps, stored per entry.
REQ-034 Without ARR_COLL_SAT_EN, the outputs SHALL be bits [15:0] truncated and sat_flag SHALL be tied 0.

Structure
REQ-035 Shared package arr_pkg SHALL hold ACC_W=24, OUT_W=16 and the collector state enum.
REQ-036 The FIFO SHALL be the sub-module arr_res_fifo, generic in width and DEPTH, with push/pop/cnt ports.

Verification
REQ-037 Reset then start at cycle 0 with c1_in=0x000100 at cycle 3 and c2_in=0x0000FF at cycle 4 (LAT=3) -> res_valid at cycle 6, res_c1=0x0100, res_c2=0x00FF, sat_flag=0.
REQ-038 hold high for 2 cycles during WAIT -> both samples shift 2 cycles later and values are unchanged.
REQ-039 With res_ready=0, four passes -> fifo_cnt=4 and start_rdy=0; one pop -> start_rdy=1 next cycle and order is preserved.
REQ-040 ARR_COLL_SAT_EN with c1_in=0x012345 and c2_in=0xFF0000 -> res_c1=0x7FFF, res_c2=0x8000, sat_flag=1; without the macro -> 0x2345, 0x0000, sat_flag=0.
REQ-041 start pulsed during CAP1 -> ignored, exactly one push.
REQ-042 rst_n low during CAP1 -> fifo_cnt=0, res_valid=0 and start_rdy=1 after release.
